// File: rtl/ps2_host_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ps2_host_tx
// Function : Host-to-device PS/2 command transmitter (open-collector oe style)
// Revision : 1.0  initial release
// ============================================================================
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int SETUP_CYCLES   = 50,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int c_INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int c_SET_W = (SETUP_CYCLES   > 1) ? $clog2(SETUP_CYCLES)   : 1;
   localparam int c_TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETUP_CYCLES - 1);
   localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INHIBIT   = 3'd1,
      S_START     = 3'd2,
      S_XMIT      = 3'd3,
      S_ACK       = 3'd4,
      S_WAIT_IDLE = 3'd5
   } state_t;

   state_t               r_state;
   logic [1:0]           r_clk_sync;
   logic [1:0]           r_data_sync;
   logic                 r_clk_prev;
   logic [9:0]           r_frame;
   logic [3:0]           r_bitcnt;
   logic [c_INH_W-1:0]   r_inh_cnt;
   logic [c_SET_W-1:0]   r_set_cnt;
   logic [c_TO_W-1:0]    r_to_cnt;
   logic                 r_clk_oe;
   logic                 r_data_oe;
   logic                 r_ready;
   logic                 r_done;
   logic                 r_error;

   logic                 w_clk_s;
   logic                 w_data_s;
   logic                 w_clk_fall;
   logic                 w_timeout;

   // Synchronizers preset high so reset never looks like bus activity
   always_ff @(posedge clk) begin
      if (rst) begin
         r_clk_sync  <= 2'b11;
         r_data_sync <= 2'b11;
         r_clk_prev  <= 1'b1;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
         r_data_sync <= {r_data_sync[0], ps2_data_in};
         r_clk_prev  <= r_clk_sync[1];
      end
   end

   assign w_clk_s    = r_clk_sync[1];
   assign w_data_s   = r_data_sync[1];
   assign w_clk_fall = r_clk_prev & ~w_clk_s;
   assign w_timeout  = (r_to_cnt == c_TO_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_ready   <= 1'b1;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_frame   <= '0;
         r_bitcnt  <= '0;
         r_inh_cnt <= '0;
         r_set_cnt <= '0;
         r_to_cnt  <= '0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_clk_oe  <= 1'b0;
               r_data_oe <= 1'b0;
               r_ready   <= 1'b1;
               if (tx_valid && r_ready) begin
                  r_ready   <= 1'b0;
                  r_frame   <= {1'b1, ~^tx_data, tx_data};
                  r_inh_cnt <= '0;
                  r_clk_oe  <= 1'b1;
                  r_state   <= S_INHIBIT;
               end
            end
            S_INHIBIT: begin
               if (r_inh_cnt == c_INH_LAST) begin
                  r_data_oe <= 1'b1;
                  r_set_cnt <= '0;
                  r_state   <= S_START;
               end else begin
                  r_inh_cnt <= r_inh_cnt + 1'b1;
               end
            end
            S_START: begin
               if (r_set_cnt == c_SET_LAST) begin
                  r_clk_oe <= 1'b0;
                  r_bitcnt <= '0;
                  r_to_cnt <= '0;
                  r_state  <= S_XMIT;
               end else begin
                  r_set_cnt <= r_set_cnt + 1'b1;
               end
            end
            S_XMIT: begin
               if (w_timeout) begin
                  r_clk_oe  <= 1'b0;
                  r_data_oe <= 1'b0;
                  r_done    <= 1'b1;
                  r_error   <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
                  // Device samples on its rising edge; we change data while it is low
                  if (w_clk_fall) begin
                     r_data_oe <= ~r_frame[r_bitcnt];
                     r_bitcnt  <= r_bitcnt + 4'd1;
                     if (r_bitcnt == 4'd9) begin
                        r_state <= S_ACK;
                     end
                  end
               end
            end
            S_ACK: begin
               if (w_timeout) begin
                  r_data_oe <= 1'b0;
                  r_done    <= 1'b1;
                  r_error   <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
                  if (w_clk_fall) begin
                     if (!w_data_s) begin
                        r_state <= S_WAIT_IDLE;
                     end else begin
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                        r_state <= S_IDLE;
                     end
                  end
               end
            end
            S_WAIT_IDLE: begin
               r_clk_oe  <= 1'b0;
               r_data_oe <= 1'b0;
               if (w_timeout) begin
                  r_done  <= 1'b1;
                  r_error <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
                  if (w_clk_s && w_data_s) begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_clk_oe  <= 1'b0;
               r_data_oe <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign ps2_clk_oe  = r_clk_oe;
   assign ps2_data_oe = r_data_oe;
   assign tx_ready    = r_ready;
   assign busy        = ~r_ready;
   assign tx_done     = r_done;
   assign tx_error    = r_error;

endmodule
`default_nettype wire
